// File: rtl/booth_controller.sv
// Control FSM for a 5x5 radix-2 Booth multiplier: sequences Y/X loads and five add/shift iterations.
// Fixed 13-edge latency from start to done; start is ignored while busy. BOOTH_START_EDGE_EN selects edge-triggered start.
module booth_controller (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic x0,
    input  logic x1,
    output logic ldY,
    output logic clrE,
    output logic ldE,
    output logic clrA,
    output logic ldA,
    output logic shA,
    output logic ldX,
    output logic shX,
    output logic sel,
    output logic busy,
    output logic done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_LOADX,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_next;
    logic       w_trigger;

`ifdef BOOTH_START_EDGE_EN
    logic r_start_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_d <= 1'b0;
        end else begin
            r_start_d <= start;
        end
    end

    assign w_trigger = start & ~r_start_d;
`else
    assign w_trigger = start;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        ldY        = 1'b0;
        clrE       = 1'b0;
        ldE        = 1'b0;
        clrA       = 1'b0;
        ldA        = 1'b0;
        shA        = 1'b0;
        ldX        = 1'b0;
        shX        = 1'b0;
        sel        = 1'b0;
        busy       = (r_state != S_IDLE);
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    w_next = S_INIT;
                end
            end
            S_INIT: begin
                clrA   = 1'b1;
                clrE   = 1'b1;
                ldY    = 1'b1;
                w_next = S_LOADX;
            end
            S_LOADX: begin
                ldX        = 1'b1;
                w_cnt_next = 3'd0;
                w_next     = S_ADD;
            end
            S_ADD: begin
                // {x0,x1}: 10 starts a run of ones (subtract), 01 ends one (add)
                case ({x0, x1})
                    2'b10: begin
                        ldA = 1'b1;
                        sel = 1'b1;
                    end
                    2'b01: begin
                        ldA = 1'b1;
                    end
                    default: begin
                        ldA = 1'b0;
                    end
                endcase
                w_next = S_SHIFT;
            end
            S_SHIFT: begin
                ldE        = 1'b1;
                shA        = 1'b1;
                shX        = 1'b1;
                w_cnt_next = r_cnt + 3'd1;
                w_next     = (r_cnt == 3'd4) ? S_DONE : S_ADD;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_controller.sv
// Bench for booth_controller: a behavioural Booth datapath closes the loop; products are scoreboarded.
module tb_booth_controller;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic x0, x1;
    logic ldY, clrE, ldE, clrA, ldA, shA, ldX, shX, sel, busy, done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_done   = 0;
    bit prev_done = 1'b0;

    logic [4:0] m_a = 5'd0;
    logic [4:0] m_x = 5'd0;
    logic [4:0] m_y = 5'd0;
    logic       m_e = 1'b0;
    logic [4:0] op_y = 5'd0;
    logic [4:0] op_x = 5'd0;

    logic [9:0] sb_q[$];
    logic [1:0] obs_pat[$];
    int         done_cyc[$];

    assign x0 = m_x[0];
    assign x1 = m_e;

    booth_controller dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .x0   (x0),
        .x1   (x1),
        .ldY  (ldY),
        .clrE (clrE),
        .ldE  (ldE),
        .clrA (clrA),
        .ldA  (ldA),
        .shA  (shA),
        .ldX  (ldX),
        .shX  (shX),
        .sel  (sel),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath: A (accumulator), X (multiplier), E (previous X LSB), Y (multiplicand)
    always @(posedge clk) begin
        if (ldY)  m_y <= op_y;
        if (ldX)  m_x <= op_x;
        if (clrA) m_a <= 5'd0;
        if (clrE) m_e <= 1'b0;
        if (ldA)  m_a <= sel ? (m_a - m_y) : (m_a + m_y);
        if (shA)  m_a <= {m_a[4], m_a[4:1]};
        if (shX)  m_x <= {m_a[0], m_x[4:1]};
        if (ldE)  m_e <= m_x[0];
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy && !ldY && !ldX && !clrA && !shA && !done)
                obs_pat.push_back({ldA, sel});
            if (done) begin
                logic [9:0] exp_p;
                n_done++;
                done_cyc.push_back(cyc);
                checks++;
                if (prev_done) begin
                    failures++;
                    $display("FAIL done_width: done high on consecutive cycles (cyc=%0d), required 1-cycle pulse", cyc);
                end
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done: got done at cyc=%0d, required no done (scoreboard empty)", cyc);
                end else begin
                    exp_p = sb_q.pop_front();
                    if ({m_a, m_x} !== exp_p) begin
                        failures++;
                        $display("FAIL product: A:X=%b, required %b", {m_a, m_x}, exp_p);
                    end
                end
            end
        end
        prev_done = rst_n && done;
    end

    function automatic logic [9:0] prod(input logic [4:0] y, input logic [4:0] x);
        int a;
        int b;
        a = $signed(y);
        b = $signed(x);
        return 10'(a * b);
    endfunction

    function automatic logic [9:0] exp_pattern(input logic [4:0] x);
        logic [9:0] v;
        logic       prev;
        v    = 10'd0;
        prev = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (x[i] && !prev)      v[9-2*i -: 2] = 2'b11;
            else if (!x[i] && prev) v[9-2*i -: 2] = 2'b10;
            else                    v[9-2*i -: 2] = 2'b00;
            prev = x[i];
        end
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({ldY, clrE, ldE, clrA, ldA, shA, ldX, shX, sel, busy, done} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b, required 00000000000",
                     {ldY, clrE, ldE, clrA, ldA, shA, ldX, shX, sel, busy, done});
        end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b after release, required 0", busy);
        end
    endtask

    task automatic run_op(input logic [4:0] y, input logic [4:0] x, input logic [9:0] exp_p);
        int         c1;
        bit         seen;
        logic [9:0] ov;
        op_y = y;
        op_x = x;
        @(negedge clk);
        obs_pat.delete();
        start = 1'b1;
        sb_q.push_back(exp_p);
        @(negedge clk);
        start = 1'b0;
        c1    = cyc;
        seen  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL latency: no done within 30 cycles, required done after 13 edges");
        end else if (cyc - c1 + 1 != 13) begin
            failures++;
            $display("FAIL latency: done after %0d edges, required 13", cyc - c1 + 1);
        end
        @(negedge clk);
        ov = 10'h3FF;
        if (obs_pat.size() == 5)
            ov = {obs_pat[0], obs_pat[1], obs_pat[2], obs_pat[3], obs_pat[4]};
        checks++;
        if (ov !== exp_pattern(x)) begin
            failures++;
            $display("FAIL ldA_pattern: x=%b got {ldA,sel} seq %b (n=%0d), required %b",
                     x, ov, obs_pat.size(), exp_pattern(x));
        end
    endtask

    task automatic test_reset_midop();
        int  shifts;
        int  base;
        bit  hit;
        op_y = 5'b01011;
        op_x = 5'b00111;
        @(negedge clk);
        start = 1'b1;
        sb_q.push_back(prod(op_y, op_x));
        @(negedge clk);
        start  = 1'b0;
        shifts = 0;
        hit    = 1'b0;
        base   = n_done;
        for (int i = 0; i < 30; i++) begin
            if (shA) shifts++;
            if (shifts == 3) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (!hit || {ldY, clrE, ldE, clrA, ldA, shA, ldX, shX, sel, busy, done} !== 11'd0) begin
            failures++;
            $display("FAIL reset_abort: hit=%0d outputs %b, required all 0", hit,
                     {ldY, clrE, ldE, clrA, ldA, shA, ldX, shX, sel, busy, done});
        end
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (n_done != base || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_done: done count delta %0d busy=%b, required 0 and 0", n_done - base, busy);
        end
        run_op(5'b01011, 5'b00111, prod(5'b01011, 5'b00111));
    endtask

    task automatic test_start_during_add();
        int base;
        bit busy_drop;
        bit pulsed;
        op_y = 5'b10110;
        op_x = 5'b01001;
        base = n_done;
        @(negedge clk);
        start = 1'b1;
        sb_q.push_back(prod(op_y, op_x));
        @(negedge clk);
        start     = 1'b0;
        busy_drop = 1'b0;
        pulsed    = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (!busy) busy_drop = 1'b1;
            if (!pulsed && busy && !ldY && !ldX && !clrA && !shA && i > 3) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (busy_drop || !pulsed) begin
            failures++;
            $display("FAIL start_in_add_busy: busy_drop=%0d pulsed=%0d, required 0 and 1", busy_drop, pulsed);
        end
        checks++;
        if (n_done - base != 1) begin
            failures++;
            $display("FAIL start_in_add_count: %0d done pulses, required 1", n_done - base);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int n_exp;
`ifdef BOOTH_START_EDGE_EN
        n_exp = 1;
`else
        n_exp = 3;
`endif
        op_y = 5'b00011;
        op_x = 5'b11010;
        base = n_done;
        done_cyc.delete();
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < n_exp; i++) sb_q.push_back(prod(op_y, op_x));
        repeat (40) @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (n_done - base != n_exp) begin
            failures++;
            $display("FAIL held_start_count: %0d operations, required %0d", n_done - base, n_exp);
        end
        for (int i = 1; i < done_cyc.size(); i++) begin
            checks++;
            if (done_cyc[i] - done_cyc[i-1] != 14) begin
                failures++;
                $display("FAIL held_start_period: done spacing %0d cycles, required 14",
                         done_cyc[i] - done_cyc[i-1]);
            end
        end
        sb_q.delete();
    endtask

    task automatic test_random();
        logic [4:0] y;
        logic [4:0] x;
        for (int i = 0; i < 8; i++) begin
            y = 5'($urandom_range(0, 30) - 15);
            x = 5'($urandom_range(0, 31));
            run_op(y, x, prod(y, x));
        end
    endtask

    initial begin
        start = 1'b0;
        rst_n = 1'b0;
        test_reset();
        run_op(5'b01010, 5'b01101, 10'b0010000010);
        run_op(5'b11101, 5'b00101, 10'b1111110001);
        run_op(5'b00111, 5'b00000, 10'b0000000000);
        run_op(5'b01111, 5'b10000, prod(5'b01111, 5'b10000));
        test_reset_midop();
        test_start_during_add();
        test_back_to_back();
        test_random();
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d expected products never produced, required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
